plot_scheduler: RTL and testbench
=================================

# plot_scheduler

Shares the single VGA plot port (x, y, colour, plot) between the game's drawing requesters: user ship, enemy grid, bullets and HUD sprites. Each requester asks for a solid rectangle. The scheduler grants one requester at a time, round-robin, and scans the rectangle as one pixel per clock into the vga_adapter. A full-screen clear request has priority over all sprite requests and is used at game start and on game over.

## Interface
- N_REQ, 4, number of sprite requesters (2..8)
- SCREEN_W, 160, horizontal pixel count
- SCREEN_H, 120, vertical pixel count

- clk  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous, active-low reset
- hold  in  1  freeze: no pixel issued, no state change (pause/game-over)
- clear_req  in  1  level request to blank whole screen
- clear_done  out  1  one-cycle pulse after last clear pixel
- req  in  N_REQ  per-requester level request
- rect_x  in  8*N_REQ  origin x, requester k at [8k+7:8k]
- rect_y  in  7*N_REQ  origin y, [7k+6:7k]
- rect_w  in  4*N_REQ  width minus 1 (1..16 pixels)
- rect_h  in  4*N_REQ  height minus 1 (1..16 pixels)
- rect_colour  in  3*N_REQ  RGB colour
- grant  out  N_REQ  one-hot, high while requester's rectangle is scanned
- done  out  N_REQ  one-cycle pulse to requester on completion
- x  out  8  pixel x to vga_adapter
- y  out  7  pixel y to vga_adapter
- colour  out  3  pixel colour to vga_adapter
- plot  out  1  write enable to vga_adapter

## Operation
- States: IDLE, CLEAR, DRAW, FINISH.
- IDLE:
  - clear_req=1 -> CLEAR, even if any req is high.
  - Otherwise, if any req is high -> DRAW. Winner is the first requester with req=1 searching from ptr upward, wrapping at N_REQ.
  - Winner's operands are latched into internal registers.
- CLEAR:
  - Scans x=0..SCREEN_W-1 inner loop, y=0..SCREEN_H-1 outer loop, colour=000, plot=1.
  - After pixel (159,119) -> FINISH with clear_done pulsed.
  - Requester req inputs are ignored during CLEAR.
- DRAW:
  - grant[k]=1.
  - Scans column offset 0..w inner loop, row offset 0..h outer loop.
  - Pixel position is x=ox+col, y=oy+row.
  - Address arithmetic is 9 bits for x and 8 bits for y.
  - Any pixel with x>=SCREEN_W or y>=SCREEN_H is clipped: it still takes its cycle, but plot=0.
  - After the last pixel -> FINISH with done[k] pulsed.
  - ptr is updated to (k+1) mod N_REQ.
- FINISH: one cycle, plot=0, grant=0, then -> IDLE.
- Requester rules:
  - Operand changes while granted have no effect, because operands are latched.
  - A req held high through done is re-arbitrated, so a requester can be granted back-to-back only if no other req is high.
- hold=1:
  - plot=0; counters, state and ptr frozen.
  - In IDLE, no grant is taken.
  - On release, the scan resumes at the exact pixel where it was frozen; no pixel is skipped or repeated.
- Reset:
  - State=IDLE, ptr=0.
  - x=0, y=0, colour=0, plot=0, grant=0, done=0, clear_done=0.
  - Reset mid-scan abandons the scan; no done pulse is issued.

## Timing
- All outputs are registered.
- Request seen in IDLE at edge t: grant and the first pixel (plot=1) are valid after edge t+1.
- Rectangle of (w+1)*(h+1) pixels: plot cycles t+1 .. t+(w+1)(h+1). done is high the following cycle, followed by FINISH.
- Minimum request-to-request spacing for one requester: (w+1)(h+1)+2 cycles.
- Clear: 19200 plot cycles. clear_done is high in cycle 19201 after entry, excluding hold cycles.
- done and clear_done are never high together. At most one grant bit is ever high.

## Test plan
- Reset, single request:
  - Stimulus: resetn low, then req[0]=1 with x=10, y=20, w=2 (3 px), h=1 (2 px), colour=100.
  - Response: six plot cycles at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), then done[0] pulse, grant[0] low.
- Round-robin:
  - Stimulus: req[0] and req[2] held high continuously.
  - Response: grants alternate 0,2,0,2.
  - Stimulus: req[1] raised while 0 is drawing.
  - Response: order becomes 0,1,2.
- Clear priority:
  - Stimulus: clear_req and req[3] rise in the same cycle.
  - Response: CLEAR runs first, 19200 pixels of colour 000 ending at (159,119), clear_done pulse, then requester 3 is drawn.
- Clipping:
  - Stimulus: x=158, y=118, w=3, h=3.
  - Response: only (158..159, 118..119) are plotted (4 plots across 16 cycles), then done.
- Hold mid-scan:
  - Stimulus: assert hold for 5 cycles after the 2nd pixel.
  - Response: plot=0 and x/y constant during hold, then scan continues at the 3rd pixel. Total plot count is unchanged.
- Reset mid-draw:
  - Stimulus: drop resetn during DRAW.
  - Response: all outputs 0 immediately, no done pulse, next request starts from ptr=0.

Source files
------------

// File: rtl/plot_scheduler.sv
// plot_scheduler: shares the single VGA plot port between N_REQ rectangle
// requesters (round-robin) and a full-screen clear that outranks them all.
// Each granted rectangle is scanned one pixel per clock, row-major, with
// off-screen pixels still taking their cycle but not asserting plot.
module plot_scheduler #(
  parameter int N_REQ    = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               hold,
  input  logic               clear_req,
  output logic               clear_done,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] rect_x,
  input  logic [7*N_REQ-1:0] rect_y,
  input  logic [4*N_REQ-1:0] rect_w,
  input  logic [4*N_REQ-1:0] rect_h,
  input  logic [3*N_REQ-1:0] rect_colour,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [2:0]         colour,
  output logic               plot
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [8:0] XLIM  = 9'(SCREEN_W);
  localparam logic [7:0] YLIM  = 8'(SCREEN_H);
  localparam logic [7:0] XLAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] YLAST = 7'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FINISH} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   sel_q, sel_d;
  logic               clr_q, clr_d;

  // Operands of the granted rectangle, frozen for the whole scan
  logic [7:0]         ox_q, ox_d;
  logic [6:0]         oy_q, oy_d;
  logic [3:0]         w_q, w_d;
  logic [3:0]         h_q, h_d;
  logic [2:0]         c_q, c_d;

  // Scan counters: column/row offset in DRAW, absolute x/y in CLEAR
  logic [7:0]         col_q, col_d;
  logic [6:0]         row_q, row_d;

  // Registered outputs
  logic [7:0]         x_q, x_d;
  logic [6:0]         y_q, y_d;
  logic [2:0]         colour_q, colour_d;
  logic               plot_q, plot_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               clr_done_q, clr_done_d;

  // Arbiter results
  logic               any_req;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   arb_idx;
  logic [7:0]         win_x;
  logic [6:0]         win_y;
  logic [3:0]         win_w;
  logic [3:0]         win_h;
  logic [2:0]         win_c;
  logic [N_REQ-1:0]   sel_oh;

  // Widened address arithmetic so a rectangle running off the edge is detectable
  logic [8:0]         px;
  logic [7:0]         py;

  assign px = {1'b0, ox_q} + {1'b0, col_q};
  assign py = {1'b0, oy_q} + {1'b0, row_q};

  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign grant      = grant_q;
  assign done       = done_q;
  assign clear_done = clr_done_q;

  // Round-robin search from ptr upward, plus mux of the winner's operands
  always_comb begin
    any_req = 1'b0;
    win     = ptr_q;
    arb_idx = '0;
    win_x   = '0;
    win_y   = '0;
    win_w   = '0;
    win_h   = '0;
    win_c   = '0;
    sel_oh  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      arb_idx = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (!any_req && req[arb_idx]) begin
        any_req = 1'b1;
        win     = arb_idx;
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (win == PTR_W'(k)) begin
        win_x = rect_x[8*k +: 8];
        win_y = rect_y[7*k +: 7];
        win_w = rect_w[4*k +: 4];
        win_h = rect_h[4*k +: 4];
        win_c = rect_colour[3*k +: 3];
      end
      sel_oh[k] = (sel_q == PTR_W'(k));
    end
  end

  // Next-state, scan counters and next output values; hold freezes everything but plot
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    clr_d      = clr_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    w_d        = w_q;
    h_d        = h_q;
    c_d        = c_q;
    col_d      = col_q;
    row_d      = row_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    grant_d    = grant_q;
    plot_d     = 1'b0;
    done_d     = '0;
    clr_done_d = 1'b0;
    if (!hold) begin
      unique case (state_q)
        IDLE: begin
          grant_d = '0;
          col_d   = '0;
          row_d   = '0;
          if (clear_req) begin
            state_d = CLEAR;
            clr_d   = 1'b1;
          end else if (any_req) begin
            state_d = DRAW;
            clr_d   = 1'b0;
            sel_d   = win;
            ox_d    = win_x;
            oy_d    = win_y;
            w_d     = win_w;
            h_d     = win_h;
            c_d     = win_c;
            ptr_d   = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
          end
        end
        CLEAR: begin
          x_d      = col_q;
          y_d      = row_q;
          colour_d = '0;
          plot_d   = 1'b1;
          grant_d  = '0;
          if (col_q == XLAST) begin
            col_d = '0;
            if (row_q == YLAST) begin
              row_d   = '0;
              state_d = FINISH;
            end else begin
              row_d = row_q + 7'd1;
            end
          end else begin
            col_d = col_q + 8'd1;
          end
        end
        DRAW: begin
          x_d      = px[7:0];
          y_d      = py[6:0];
          colour_d = c_q;
          plot_d   = (px < XLIM) && (py < YLIM);
          grant_d  = sel_oh;
          if (col_q[3:0] == w_q) begin
            col_d = '0;
            if (row_q[3:0] == h_q) begin
              state_d = FINISH;
            end else begin
              row_d = row_q + 7'd1;
            end
          end else begin
            col_d = col_q + 8'd1;
          end
        end
        FINISH: begin
          grant_d = '0;
          state_d = IDLE;
          if (clr_q) begin
            clr_done_d = 1'b1;
          end else begin
            done_d = sel_oh;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration pointer, latched operands, scan counters and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q      <= '0;
      sel_q      <= '0;
      clr_q      <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      c_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
      clr_done_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      clr_q      <= clr_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      w_q        <= w_d;
      h_q        <= h_d;
      c_q        <= c_d;
      col_q      <= col_d;
      row_q      <= row_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      clr_done_q <= clr_done_d;
    end
  end

endmodule

// File: tb/tb_plot_scheduler.sv
// Testbench for plot_scheduler: a transaction-level model predicts the
// ordered stream of plotted pixels and completion pulses; a monitor pops
// and compares them as the DUT produces them.
module tb_plot_scheduler;

  localparam int N  = 4;
  localparam int SW = 160;
  localparam int SH = 120;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           hold = 1'b0;
  logic           clear_req = 1'b0;
  logic           clear_done;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] rect_x = '0;
  logic [7*N-1:0] rect_y = '0;
  logic [4*N-1:0] rect_w = '0;
  logic [4*N-1:0] rect_h = '0;
  logic [3*N-1:0] rect_colour = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           plot;

  plot_scheduler #(.N_REQ(N), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .resetn(resetn), .hold(hold), .clear_req(clear_req),
    .clear_done(clear_done), .req(req), .rect_x(rect_x), .rect_y(rect_y),
    .rect_w(rect_w), .rect_h(rect_h), .rect_colour(rect_colour),
    .grant(grant), .done(done), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  // kind: 0 = plotted pixel, 1 = done pulse, 2 = clear_done pulse
  typedef struct {
    int kind;
    int px;
    int py;
    int c;
    int id;
    int ncyc;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;

  // Requester operands and remaining request counts (model + agent state)
  int ox[N], oy[N], ow[N], oh[N], oc[N], cnt[N];
  int mptr = 0;

  int late_k = -1;
  bit late_done = 1'b0;
  bit scramble = 1'b0;
  bit rand_hold = 1'b0;
  int hold_cnt = 0;
  int hold_after = -1;
  int plots_seen = 0;

  logic hold_seen;
  always @(posedge clk or negedge resetn)
    if (!resetn) hold_seen <= 1'b0;
    else         hold_seen <= hold;

  task automatic chk(input bit ok, input string name, input string detail);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // ---------------- monitor ----------------
  int         gcyc = 0;
  logic [7:0] x_prev = '0;
  logic [6:0] y_prev = '0;
  ev_t        me;
  logic [N-1:0] eg;

  always @(negedge clk) begin
    if (!resetn) begin
      gcyc = 0;
    end else begin
      if (hold_seen) begin
        chk(plot == 1'b0, "hold_plot", $sformatf("got plot=%0d expected 0", plot));
        chk(x == x_prev && y == y_prev, "hold_xy",
            $sformatf("got (%0d,%0d) expected (%0d,%0d)", x, y, x_prev, y_prev));
      end
      chk($onehot0(grant) && !((done != '0) && clear_done), "exclusive",
          $sformatf("got grant=%b done=%b clear_done=%b expected onehot0 and no overlap",
                    grant, done, clear_done));
      if (grant != '0 && !hold_seen) gcyc++;
      if (plot) begin
        if (q.size() == 0 || q[0].kind != 0) begin
          chk(1'b0, "unexpected_plot", $sformatf("got plot at (%0d,%0d) expected none", x, y));
        end else begin
          me = q.pop_front();
          eg = '0;
          if (me.id >= 0) eg[me.id] = 1'b1;
          chk(int'(x) == me.px && int'(y) == me.py && int'(colour) == me.c && grant == eg,
              "pixel", $sformatf("got (%0d,%0d) c=%0d g=%b expected (%0d,%0d) c=%0d g=%b",
                                 x, y, colour, grant, me.px, me.py, me.c, eg));
        end
      end
      if (done != '0) begin
        if (q.size() == 0 || q[0].kind != 1) begin
          chk(1'b0, "unexpected_done", $sformatf("got done=%b expected none", done));
        end else begin
          me = q.pop_front();
          eg = '0;
          eg[me.id] = 1'b1;
          chk(done == eg && gcyc == me.ncyc, "done",
              $sformatf("got done=%b cycles=%0d expected done=%b cycles=%0d",
                        done, gcyc, eg, me.ncyc));
        end
        gcyc = 0;
      end
      if (clear_done) begin
        if (q.size() == 0 || q[0].kind != 2) begin
          chk(1'b0, "unexpected_clear_done", "got clear_done=1 expected 0");
        end else begin
          me = q.pop_front();
          chk(grant == '0, "clear_done", $sformatf("got grant=%b expected 0", grant));
        end
      end
    end
    x_prev = x;
    y_prev = y;
  end

  // ---------------- reference model ----------------
  task automatic push_rect(input int k);
    for (int r = 0; r <= oh[k]; r++)
      for (int cc = 0; cc <= ow[k]; cc++)
        if (ox[k] + cc < SW && oy[k] + r < SH)
          q.push_back('{0, ox[k] + cc, oy[k] + r, oc[k], k, 0});
    q.push_back('{1, 0, 0, 0, k, (ow[k] + 1) * (oh[k] + 1)});
  endtask

  task automatic push_clear();
    for (int yy = 0; yy < SH; yy++)
      for (int xx = 0; xx < SW; xx++)
        q.push_back('{0, xx, yy, 0, -1, 0});
    q.push_back('{2, 0, 0, 0, -1, 0});
  endtask

  // Serve outstanding requests: first pending requester at or above the pointer
  task automatic model_batch(input int late);
    int mc[N];
    int p;
    int w;
    bit added;
    for (int k = 0; k < N; k++) mc[k] = cnt[k];
    p = mptr;
    added = 1'b0;
    w = 0;
    while (w >= 0) begin
      w = -1;
      for (int i = 0; i < N; i++)
        if (w < 0 && mc[(p + i) % N] > 0) w = (p + i) % N;
      if (w >= 0) begin
        push_rect(w);
        mc[w]--;
        p = (w + 1) % N;
        if (late >= 0 && !added) begin
          mc[late]++;
          added = 1'b1;
        end
      end
    end
    mptr = p;
  endtask

  // ---------------- stimulus / requester agents ----------------
  task automatic drive_ops(input int k);
    rect_x[8*k +: 8]      = 8'(ox[k]);
    rect_y[7*k +: 7]      = 7'(oy[k]);
    rect_w[4*k +: 4]      = 4'(ow[k]);
    rect_h[4*k +: 4]      = 4'(oh[k]);
    rect_colour[3*k +: 3] = 3'(oc[k]);
  endtask

  task automatic set_ops(input int k, input int xx, input int yy, input int w,
                         input int h, input int c);
    ox[k] = xx; oy[k] = yy; ow[k] = w; oh[k] = h; oc[k] = c;
    drive_ops(k);
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (done[k]) begin
        if (cnt[k] > 0) cnt[k]--;
        drive_ops(k);
        if (cnt[k] == 0) req[k] = 1'b0;
      end else if (grant[k] && scramble) begin
        rect_x[8*k +: 8]      = 8'($urandom);
        rect_y[7*k +: 7]      = 7'($urandom);
        rect_w[4*k +: 4]      = 4'($urandom);
        rect_h[4*k +: 4]      = 4'($urandom);
        rect_colour[3*k +: 3] = 3'($urandom);
      end
    end
    if (clear_done) clear_req = 1'b0;
    if (late_k >= 0 && !late_done && grant != '0) begin
      req[late_k] = 1'b1;
      cnt[late_k] = 1;
      late_done = 1'b1;
    end
    if (plot) plots_seen++;
    if (hold_cnt > 0) begin
      hold = 1'b1;
      hold_cnt--;
    end else if (hold_after > 0 && plot && plots_seen == hold_after) begin
      hold = 1'b1;
      hold_cnt = 4;
      hold_after = -1;
    end else begin
      hold = rand_hold && ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic start_batch(input int late);
    late_k = late;
    late_done = 1'b0;
    plots_seen = 0;
    model_batch(late);
    for (int k = 0; k < N; k++) if (cnt[k] > 0) req[k] = 1'b1;
  endtask

  function automatic bit busy();
    bit b;
    b = (q.size() != 0) || clear_req;
    for (int k = 0; k < N; k++) if (cnt[k] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run(input int budget, input string name);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk(n < budget, name, $sformatf("got %0d cycles without completion expected < %0d", n, budget));
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      cnt[k] = 0;
      set_ops(k, 0, 0, 0, 0, 0);
    end

    // Reset state
    #1;
    chk(x == 8'd0 && y == 7'd0, "reset_xy", $sformatf("got (%0d,%0d) expected (0,0)", x, y));
    chk(colour == 3'd0 && plot == 1'b0, "reset_pix",
        $sformatf("got colour=%0d plot=%0d expected 0,0", colour, plot));
    chk(grant == '0 && done == '0 && clear_done == 1'b0, "reset_ctl",
        $sformatf("got grant=%b done=%b clear_done=%b expected zeros", grant, done, clear_done));
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step();

    // Single request from requester 0
    set_ops(0, 10, 20, 2, 1, 4);
    cnt[0] = 1;
    start_batch(-1);
    run(2000, "single_timeout");

    // Two requesters held for two rounds each
    set_ops(0, 40, 50, 3, 2, 1);
    set_ops(2, 70, 30, 1, 4, 2);
    cnt[0] = 2;
    cnt[2] = 2;
    start_batch(-1);
    run(2000, "rr_timeout");

    // Reset in the middle of a draw
    set_ops(2, 5, 5, 15, 15, 3);
    cnt[2] = 1;
    start_batch(-1);
    begin
      int n;
      n = 0;
      while (grant[2] != 1'b1 && n < 100) begin
        step();
        n++;
      end
      chk(n < 100, "grant_wait", $sformatf("got %0d cycles without grant expected < 100", n));
    end
    step();
    step();
    resetn = 1'b0;
    #1;
    chk(x == 8'd0 && y == 7'd0 && colour == 3'd0 && plot == 1'b0, "midreset_pix",
        $sformatf("got (%0d,%0d) c=%0d plot=%0d expected zeros", x, y, colour, plot));
    chk(grant == '0 && done == '0 && clear_done == 1'b0, "midreset_ctl",
        $sformatf("got grant=%b done=%b expected zeros", grant, done));
    q.delete();
    for (int k = 0; k < N; k++) cnt[k] = 0;
    req = '0;
    mptr = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step();
    set_ops(1, 100, 60, 2, 2, 5);
    set_ops(3, 20, 90, 4, 1, 6);
    cnt[1] = 1;
    cnt[3] = 1;
    start_batch(-1);
    run(2000, "post_reset_timeout");

    // Requester 1 joins while 0 draws: order 0,1,2
    set_ops(0, 0, 0, 5, 3, 7);
    set_ops(1, 30, 30, 2, 2, 1);
    set_ops(2, 60, 60, 3, 3, 2);
    cnt[0] = 1;
    cnt[2] = 1;
    start_batch(1);
    run(2000, "late_timeout");
    late_k = -1;

    // Clipping at the bottom-right corner
    set_ops(1, 158, 118, 3, 3, 5);
    cnt[1] = 1;
    start_batch(-1);
    run(2000, "clip_timeout");

    // Hold for 5 cycles after the 2nd pixel
    set_ops(3, 30, 40, 3, 2, 6);
    cnt[3] = 1;
    hold_after = 2;
    start_batch(-1);
    run(2000, "hold_timeout");

    // Clear and requester 3 rise together: clear first
    set_ops(3, 80, 80, 2, 2, 3);
    cnt[3] = 1;
    push_clear();
    clear_req = 1'b1;
    start_batch(-1);
    run(25000, "clear_timeout");

    // Randomised batches with random hold and operand changes while granted
    rand_hold = 1'b1;
    scramble = 1'b1;
    for (int b = 0; b < 20; b++) begin
      bit any;
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
        cnt[k] = $urandom_range(0, 2);
        if (cnt[k] > 0) any = 1'b1;
        set_ops(k, $urandom_range(0, 165), $urandom_range(0, 127),
                $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      end
      if (!any) cnt[$urandom_range(0, N - 1)] = 1;
      start_batch(-1);
      run(20000, "rand_timeout");
    end
    rand_hold = 1'b0;
    scramble = 1'b0;
    hold = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
